// File: rtl/aes_key_schedule_store_if.sv
// rtl/aes_key_schedule_store_if.sv - key-load and round-key read bundle for the AES key schedule store
interface aes_key_schedule_store_if #(
  parameter int KEY_W = 256
);
  logic             start;
  logic [1:0]       alg;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             ready;
  logic             alg_err;
  logic             rd_en;
  logic [3:0]       rd_idx;
  logic             rd_inv;
  logic [127:0]     rk_out;
  logic             rk_valid;
  logic             rk_err;

  modport master (
    output start, alg, key, rd_en, rd_idx, rd_inv,
    input  busy, ready, alg_err, rk_out, rk_valid, rk_err
  );

  modport slave (
    input  start, alg, key, rd_en, rd_idx, rd_inv,
    output busy, ready, alg_err, rk_out, rk_valid, rk_err
  );
endinterface

// File: rtl/aes_key_schedule_store.sv
// rtl/aes_key_schedule_store.sv - iterative AES-128/192/256 key expansion with round-key store
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  logic [7:0] w_inv;

  assign w_inv = ginv(i_a);
  assign o_s   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule_store #(
  parameter int MAX_WORDS = 60,
  parameter int KEY_W     = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  aes_key_schedule_store_if.slave bus
);
  localparam int AW = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_ready;
  logic            r_alg_err;
  logic [AW-1:0]   r_j;
  logic [AW-1:0]   r_last;
  logic [3:0]      r_jmod;
  logic [3:0]      r_nk;
  logic [3:0]      r_nr;
  logic [7:0]      r_rcon;
  logic [31:0]     r_mem [MAX_WORDS];
  logic [127:0]    r_rk_out;
  logic            r_rk_valid;
  logic            r_rk_err;

  logic [3:0]      w_nk_in;
  logic [3:0]      w_nr_in;
  logic [AW-1:0]   w_last_in;
  logic            w_start_ok;
  logic            w_load;
  logic [31:0]     w_prev;
  logic [31:0]     w_back;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub_out;
  logic [31:0]     w_temp;
  logic [31:0]     w_new;
  logic [7:0]      w_rcon_next;
  logic [3:0]      w_ridx;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   w_a1;
  logic [AW-1:0]   w_a2;
  logic [AW-1:0]   w_a3;
  logic            w_rd_reject;

  // Mode constants for the algorithm presented with start
  always_comb begin
    w_nk_in   = 4'd8;
    w_nr_in   = 4'd14;
    w_last_in = AW'(59);
    case (bus.alg)
      2'b00: begin
        w_nk_in   = 4'd4;
        w_nr_in   = 4'd10;
        w_last_in = AW'(43);
      end
      2'b01: begin
        w_nk_in   = 4'd6;
        w_nr_in   = 4'd12;
        w_last_in = AW'(51);
      end
      default: begin
        w_nk_in   = 4'd8;
        w_nr_in   = 4'd14;
        w_last_in = AW'(59);
      end
    endcase
  end

  assign w_start_ok = bus.start && (r_state != EXPAND);
  assign w_load     = w_start_ok && (bus.alg != 2'b11);

  // Next schedule word: w[j] = w[j-Nk] ^ f(w[j-1]); r_jmod tracks j mod Nk
  assign w_prev   = r_mem[r_j - AW'(1)];
  assign w_back   = r_mem[r_j - AW'(r_nk)];
  assign w_sub_in = (r_jmod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .i_a (w_sub_in[8*g +: 8]),
        .o_s (w_sub_out[8*g +: 8])
      );
    end
  endgenerate

  assign w_temp = (r_jmod == 4'd0)                      ? (w_sub_out ^ {r_rcon, 24'h0}) :
                  ((r_nk == 4'd8) && (r_jmod == 4'd4))  ? w_sub_out :
                                                          w_prev;
  assign w_new       = w_back ^ w_temp;
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Control FSM: accepts start, steps j through the schedule, flags completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_alg_err <= 1'b0;
      r_j       <= '0;
      r_last    <= '0;
      r_jmod    <= 4'd0;
      r_nk      <= 4'd4;
      r_nr      <= 4'd10;
      r_rcon    <= 8'h01;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.alg == 2'b11) begin
              r_alg_err <= 1'b1;
              r_ready   <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_nk      <= w_nk_in;
              r_nr      <= w_nr_in;
              r_last    <= w_last_in;
              r_j       <= AW'(w_nk_in);
              r_jmod    <= 4'd0;
              r_rcon    <= 8'h01;
              r_alg_err <= 1'b0;
              r_ready   <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= EXPAND;
            end
          end
        end
        EXPAND: begin
          r_j    <= r_j + AW'(1);
          r_jmod <= (r_jmod == r_nk - 4'd1) ? 4'd0 : r_jmod + 4'd1;
          if (r_jmod == 4'd0) r_rcon <= w_rcon_next;
          if (r_j == r_last) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Word store: key words on an accepted start, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(w_nk_in)) r_mem[AW'(i)] <= bus.key[KEY_W-1-32*i -: 32];
      end
    end else if (r_state == EXPAND) begin
      r_mem[r_j] <= w_new;
    end
  end

  // Read addressing; a start in the same cycle invalidates the read because the store is being reloaded
  assign w_ridx      = bus.rd_inv ? (r_nr - bus.rd_idx) : bus.rd_idx;
  assign w_base      = AW'({w_ridx, 2'b00});
  assign w_a1        = w_base + AW'(1);
  assign w_a2        = w_base + AW'(2);
  assign w_a3        = w_base + AW'(3);
  assign w_rd_reject = !r_ready || bus.start || (bus.rd_idx > r_nr);

  // Registered read port: one response per request, rk_out holds on rejection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_out   <= '0;
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      if (bus.rd_en) begin
        if (w_rd_reject) begin
          r_rk_err <= 1'b1;
        end else begin
          r_rk_valid <= 1'b1;
          r_rk_out   <= {r_mem[w_base], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
        end
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.ready    = r_ready;
  assign bus.alg_err  = r_alg_err;
  assign bus.rk_out   = r_rk_out;
  assign bus.rk_valid = r_rk_valid;
  assign bus.rk_err   = r_rk_err;
endmodule

// File: tb/tb_aes_key_schedule_store.sv
// tb/tb_aes_key_schedule_store.sv - scoreboard bench for aes_key_schedule_store
module tb_aes_key_schedule_store;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_store_if #(.KEY_W(256)) bus ();

  aes_key_schedule_store #(.MAX_WORDS(60), .KEY_W(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  typedef struct {
    logic         ok;
    logic [127:0] data;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic rd(input string nm, input logic [3:0] idx, input logic inv,
                    input logic ok, input logic [127:0] d);
    exp_t e;
    e.ok   = ok;
    e.data = d;
    sb_q.push_back(e);
    name_q.push_back(nm);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    bus.rd_inv = inv;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic start_exp(input logic [1:0] a, input logic [255:0] k);
    bus.alg   = a;
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int n0, input int req);
    int n;
    n = n0;
    while (!bus.ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 128'(n), 128'(req));
  endtask

  // Monitor: every response the DUT presents is matched against the next scoreboard entry
  always @(negedge clk) begin : mon
    exp_t  e;
    string nm;
    if (rst_n && (bus.rk_valid || bus.rk_err)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: valid=%0b err=%0b, required no response", bus.rk_valid, bus.rk_err);
      end else begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        if (bus.rk_valid !== e.ok || bus.rk_err !== !e.ok || (e.ok && bus.rk_out !== e.data)) begin
          errors++;
          $display("FAIL %s: valid=%0b err=%0b data=%h, required valid=%0b err=%0b data=%h",
                   nm, bus.rk_valid, bus.rk_err, bus.rk_out, e.ok, !e.ok, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.alg    = 2'b00;
    bus.key    = '0;
    bus.rd_en  = 1'b0;
    bus.rd_idx = 4'd0;
    bus.rd_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 128'({bus.busy, bus.ready, bus.alg_err, bus.rk_valid, bus.rk_err}), 128'd0);
    chk("reset_rk_out", bus.rk_out, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd("rd_no_schedule", 4'd0, 1'b0, 1'b0, 128'd0);

    // AES-128
    start_exp(2'b00, K128);
    chk("busy_128", 128'(bus.busy), 128'd1);
    wait_ready("latency_128", 0, 40);
    rd("fwd128_1", 4'd1, 1'b0, 1'b1, R128_1);
    rd("fwd128_10", 4'd10, 1'b0, 1'b1, R128_10);
    rd("fwd128_0", 4'd0, 1'b0, 1'b1, R128_0);
    rd("inv128_0", 4'd0, 1'b1, 1'b1, R128_10);
    rd("inv128_10", 4'd10, 1'b1, 1'b1, R128_0);
    rd("idx11_128", 4'd11, 1'b0, 1'b0, 128'd0);

    // AES-192 with a read while busy and an ignored second start
    start_exp(2'b01, K192);
    rd("rd_busy", 4'd0, 1'b0, 1'b0, 128'd0);
    bus.alg   = 2'b00;
    bus.key   = K128;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_192", 128'({bus.busy, bus.ready}), 128'b10);
    wait_ready("latency_192", 2, 46);
    rd("inv192_0", 4'd0, 1'b1, 1'b1, R192_12);
    rd("fwd192_12", 4'd12, 1'b0, 1'b1, R192_12);
    rd("fwd192_0", 4'd0, 1'b0, 1'b1, R192_0);
    rd("idx13_192", 4'd13, 1'b0, 1'b0, 128'd0);

    // Reserved mode
    start_exp(2'b11, K192);
    chk("alg_err_flags", 128'({bus.alg_err, bus.ready, bus.busy}), 128'b100);
    rd("rd_after_alg_err", 4'd0, 1'b0, 1'b0, 128'd0);

    // AES-256
    start_exp(2'b10, K256);
    chk("alg_err_clear", 128'({bus.alg_err, bus.busy}), 128'b01);
    wait_ready("latency_256", 0, 52);
    rd("fwd256_14", 4'd14, 1'b0, 1'b1, R256_14);
    rd("fwd256_0", 4'd0, 1'b0, 1'b1, R256_0);
    rd("fwd256_1", 4'd1, 1'b0, 1'b1, R256_1);
    rd("inv256_14", 4'd14, 1'b1, 1'b1, R256_0);
    rd("inv256_0", 4'd0, 1'b1, 1'b1, R256_14);
    rd("idx15_256", 4'd15, 1'b0, 1'b0, 128'd0);

    // Restart from DONE with a read in the same cycle
    begin
      exp_t e;
      e.ok   = 1'b0;
      e.data = 128'd0;
      sb_q.push_back(e);
      name_q.push_back("rd_on_restart");
    end
    bus.alg    = 2'b00;
    bus.key    = K128;
    bus.start  = 1'b1;
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd14;
    bus.rd_inv = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    chk("restart_ready_drop", 128'({bus.ready, bus.busy}), 128'b01);
    wait_ready("latency_restart", 0, 40);
    rd("restart_fwd10", 4'd10, 1'b0, 1'b1, R128_10);
    rd("restart_fwd0", 4'd0, 1'b0, 1'b1, R128_0);

    // Reset in the middle of an AES-256 expansion
    start_exp(2'b10, K256);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", 128'({bus.busy, bus.ready, bus.alg_err, bus.rk_valid, bus.rk_err}), 128'd0);
    chk("midreset_rk_out", bus.rk_out, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_ready", 128'({bus.ready, bus.busy}), 128'd0);
    start_exp(2'b00, K128);
    wait_ready("latency_after_reset", 0, 40);
    rd("after_reset_fwd1", 4'd1, 1'b0, 1'b1, R128_1);
    rd("after_reset_fwd10", 4'd10, 1'b0, 1'b1, R128_10);

    repeat (3) @(posedge clk);
    #1;
    chk("responses_outstanding", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule_store.md
Name: aes_key_schedule_store

Overview:
- Iterative, multi-mode successor to the combinational AES-192 inverse-key block.
- Expands a 128-, 192- or 256-bit cipher key into all round keys, one 32-bit word per clock, and holds them in an internal word store.
- Serves round keys in forward (encrypt) or inverse (decrypt) order through a registered read port.
- Sits between key load and the round datapath.

Parameters:
- MAX_WORDS, 60, depth of the word store (4*(14+1)); must be at least 60.
- KEY_W, 256, width of the key input bus; must equal 256.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to expand `key` using `alg`
- alg  in  2  mode: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved
- key  in  256  cipher key, MSB-aligned; word w0 = key[255:224]; 128-bit mode uses key[255:128], 192-bit mode uses key[255:64]
- busy  out  1  expansion in progress
- ready  out  1  store holds a complete schedule for the latched mode
- alg_err  out  1  last start carried alg = 11
- rd_en  in  1  round-key read request
- rd_idx  in  4  round index 0..Nr
- rd_inv  in  1  0 = forward order, 1 = inverse order
- rk_out  out  128  round key; [127:96] = lowest-numbered word
- rk_valid  out  1  rk_out is valid this cycle
- rk_err  out  1  read rejected (not ready, or rd_idx > Nr)

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - busy, ready, alg_err, rk_valid and rk_err clear to 0; rk_out clears to 0.
  - Rcon register loads 0x01; the word store need not be cleared.
- Mode constants:
  - AES-128: Nk = 4, Nr = 10, total 44 words.
  - AES-192: Nk = 6, Nr = 12, total 52 words.
  - AES-256: Nk = 8, Nr = 14, total 60 words.
- States:
  - IDLE: no schedule.
  - EXPAND: busy = 1.
  - DONE: ready = 1.
- start accepted (state IDLE or DONE):
  - If alg = 11: alg_err = 1, state goes to IDLE, ready = 0.
  - Otherwise, on the same edge: latch mode, write w0..w(Nk-1) from key, set j = Nk, set Rcon = 0x01, set alg_err = 0, ready = 0, busy = 1, state goes to EXPAND.
- start while in EXPAND is ignored.
- EXPAND, one word per cycle:
  - temp = w[j-1].
  - If j mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon = xtime(Rcon) (polynomial 0x11B).
  - Else if Nk = 8 and j mod 8 = 4: temp = SubWord(temp).
  - w[j] = w[j-Nk] ^ temp; j increments.
  - SubWord uses four instances of the existing forward S-box.
  - The j mod Nk counter is a separate 0..Nk-1 counter; no divider.
- After writing the last word (j = total-1):
  - Next cycle: busy = 0, ready = 1, state goes to DONE.
  - Latency from the start edge to ready = 1: 40 / 46 / 52 cycles for 128 / 192 / 256.
- Read port, one-cycle registered latency:
  - rd_en sampled at edge t; result is visible after edge t (rk_valid = 1 for exactly one cycle per request).
  - Forward order: rk_out = w[4*rd_idx .. 4*rd_idx+3].
  - Inverse order: rk_out = w[4*(Nr-rd_idx) .. +3], so inverse index 0 returns the last round key.
  - Reads are back-to-back capable, one per cycle.
- Read errors:
  - If ready = 0 or rd_idx > Nr: rk_valid = 0, rk_err = 1 for one cycle, rk_out holds its previous value.
  - rd_en = 0: rk_valid = 0, rk_err = 0.
- Restart: start accepted in DONE while rd_en is high in the same cycle.
  - The read is processed against the old state and rejected, because ready is taken at its pre-edge value of 1 and the store is being overwritten, so it is flagged rk_err.
  - Rule: a read is valid only if ready = 1 and start = 0 in the request cycle.
- Reset mid-EXPAND aborts expansion; the store contents are don't-care and ready stays 0 until a new start completes.
- All index arithmetic is unsigned; store address width = clog2(MAX_WORDS).

Test Plan:
- AES-128 expansion:
  - Stimulus: alg = 00, key = 2b7e1516 28aed2a6 abf71588 09cf4f3c, start pulse.
  - Required: ready rises 40 cycles after start.
  - Forward idx 1 reads a0fafe17 88542cb1 23a33939 2a6c7605.
  - Forward idx 10 reads d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- AES-192 expansion:
  - Stimulus: alg = 01, key = 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required: ready after 46 cycles.
  - Inverse idx 0 equals forward idx 12 and reads e98ba06f 448c773c 8ecc7204 01002202.
  - Forward idx 0 reads 8e73b0f7 da0e6452 c810f32b 809079e5.
- AES-256 expansion:
  - Stimulus: alg = 10, key = 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required: ready after 52 cycles.
  - Forward idx 14 reads fe4890d1 e6188d0b 046df344 706c631e.
- Error handling:
  - rd_en while busy: rk_err = 1, rk_valid = 0.
  - AES-128 mode, rd_idx = 11: rk_err = 1.
  - alg = 11 start: alg_err = 1, ready = 0.
  - A second start during EXPAND: ignored; the cycle count is unchanged.
- Reset and restart:
  - Assert rst_n = 0 at cycle 20 of an AES-256 expansion: all outputs are 0 immediately.
  - A new AES-128 start after reset produces correct keys.
  - Restarting from DONE with a different key overwrites the old schedule; ready drops until the new expansion completes.
